// File: rtl/mem_pkg.sv
// Shared widths and request/response record types for the memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              err;
  } mem_resp_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response queue; head is presented combinationally, zero when empty.
module resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output logic valid_o,
  output T     head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, full, do_push, do_pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CNT_W'(DEPTH));
    do_pop   = pop_i & ~empty;
    do_push  = push_i & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    valid_o = ~empty;
    head_o  = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full && !pop_i))
    else $error("resp_fifo overflow");

endmodule

// File: rtl/mem_responder.sv
// Word memory with a fixed-latency response pipeline feeding an in-order queue.
// Acceptance is throttled by a registered credit covering pipeline plus queue.
module mem_responder
  import mem_pkg::TAG_W, mem_pkg::mem_req_t, mem_pkg::mem_resp_t, mem_pkg::is_misaligned;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic              resp_err_o
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0]  mem_q [MEM_WORDS];
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  mem_resp_t          pipe_resp_q [LATENCY];
  mem_resp_t          pipe_resp_d [LATENCY];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, ready_d;

  mem_req_t           req;
  mem_resp_t          acc_resp, head;
  logic               accept, pop, fifo_valid, wr_en, misaligned;
  logic [IDX_W-1:0]   idx;
  logic               addr_unused;

  always_comb begin
    req         = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, tag: req_tag_i};
    accept      = req_valid_i & ready_q;
    misaligned  = is_misaligned(req.addr[1:0]);
    idx         = req.addr[IDX_W+1:2];
    addr_unused = ^req.addr[ADDR_W-1:IDX_W+2];
    wr_en       = accept & req.we & ~misaligned;

    // Loads read before this edge's write, so a store's own response carries wdata.
    acc_resp.tag = req.tag;
    acc_resp.err = misaligned;
    if (misaligned)  acc_resp.data = '0;
    else if (req.we) acc_resp.data = req.wdata;
    else             acc_resp.data = mem_q[idx];

    pipe_vld_d[0]  = accept;
    pipe_resp_d[0] = acc_resp;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_resp_d[i] = pipe_resp_q[i-1];
    end

    pop     = fifo_valid & resp_ready_i;
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + CNT_W'(1);
    else if (!accept && pop) count_d = count_q - CNT_W'(1);
    ready_d = (count_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= req.wdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) pipe_resp_q[i] <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_resp_q <= pipe_resp_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
    end
  end

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (mem_resp_t)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .push_i  (pipe_vld_q[LATENCY-1]),
    .data_i  (pipe_resp_q[LATENCY-1]),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .head_o  (head)
  );

  assign req_ready_o  = ready_q;
  assign resp_valid_o = fifo_valid;
  assign resp_rdata_o = head.data;
  assign resp_tag_o   = head.tag;
  assign resp_err_o   = head.err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_tag_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [3:0]  resp_tag_o;
  logic        resp_err_o;

  int checks   = 0;
  int failures = 0;

  mem_responder #(
    .ADDR_W(32), .DATA_W(32), .MEM_WORDS(256), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Drives one request with resp_ready=1 and returns the response fields and accept-to-valid cycles.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] tag, output logic [31:0] rd, output logic [3:0] tg,
                      output logic er, output int lat);
    int w = 0;
    resp_ready_i = 1'b1;
    req_valid_i  = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_tag_i = tag;
    while (req_ready_o !== 1'b1 && w < 20) begin tick; w++; end
    tick;
    req_valid_i = 1'b0;
    lat = 0;
    while (resp_valid_o !== 1'b1 && lat < 20) begin tick; lat++; end
    rd = resp_rdata_o; tg = resp_tag_o; er = resp_err_o;
    tick;
  endtask

  task automatic test_reset;
    reset_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_wdata_i = '0; req_tag_i = '0; resp_ready_i = 1'b0;
    #2 reset_i = 1'b1;
    tick;
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready_o); end
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", resp_valid_o); end
    checks++; if ({resp_rdata_o, resp_tag_o, resp_err_o} !== 37'd0) begin
      failures++; $display("FAIL rst_resp got=%h/%h/%b exp=0", resp_rdata_o, resp_tag_o, resp_err_o); end
    tick;
    reset_i = 1'b0;
    tick;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", req_ready_o); end
  endtask

  task automatic test_store_load;
    resp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'hDEADBEEF; req_tag_i = 4'd3;
    tick;
    req_we_i = 1'b0; req_wdata_i = '0; req_tag_i = 4'd4;
    tick;
    req_valid_i = 1'b0;
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL sl_early got=%b exp=0", resp_valid_o); end
    tick;
    checks++; if ({resp_valid_o, resp_tag_o, resp_rdata_o, resp_err_o} !== {1'b1, 4'd3, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL sl_store got=v%b t%0d %h e%b exp=v1 t3 deadbeef e0", resp_valid_o, resp_tag_o, resp_rdata_o, resp_err_o); end
    tick;
    checks++; if ({resp_valid_o, resp_tag_o, resp_rdata_o, resp_err_o} !== {1'b1, 4'd4, 32'hDEADBEEF, 1'b0}) begin
      failures++; $display("FAIL sl_load got=v%b t%0d %h e%b exp=v1 t4 deadbeef e0", resp_valid_o, resp_tag_o, resp_rdata_o, resp_err_o); end
    tick;
    checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL sl_drain got=%b exp=0", resp_valid_o); end
  endtask

  task automatic test_backpressure;
    int acc_n = 0, got_n = 0, first_pop = -1, acc4_cyc = -1;
    logic [3:0] got_tags [6];
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h10;
    for (int i = 0; i < 8; i++) begin
      req_tag_i = 4'(acc_n);
      checks++; if (req_ready_o !== (i < DEPTH)) begin
        failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, req_ready_o, i < DEPTH); end
      if (resp_valid_o === 1'b1) begin
        checks++; if (resp_tag_o !== 4'd0 || resp_rdata_o !== 32'hDEADBEEF) begin
          failures++; $display("FAIL bp_hold cyc=%0d got=t%0d %h exp=t0 deadbeef", i, resp_tag_o, resp_rdata_o); end
      end
      if (req_ready_o === 1'b1) acc_n++;
      tick;
    end
    checks++; if (acc_n != DEPTH) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc_n, DEPTH); end
    resp_ready_i = 1'b1;
    for (int c = 0; c < 30 && got_n < 6; c++) begin
      req_valid_i = (acc_n < 6);
      req_tag_i   = 4'(acc_n);
      if (resp_valid_o === 1'b1) begin
        got_tags[got_n] = resp_tag_o;
        checks++; if (resp_rdata_o !== 32'hDEADBEEF || resp_err_o !== 1'b0) begin
          failures++; $display("FAIL bp_data idx=%0d got=%h e%b exp=deadbeef e0", got_n, resp_rdata_o, resp_err_o); end
        if (got_n == 0) first_pop = c;
        got_n++;
      end
      if (req_valid_i && req_ready_o === 1'b1) begin
        if (acc_n == 4) acc4_cyc = c;
        acc_n++;
      end
      tick;
    end
    req_valid_i = 1'b0;
    checks++; if (got_n != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got_n); end
    for (int i = 0; i < got_n; i++) begin
      checks++; if (got_tags[i] !== 4'(i)) begin failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got_tags[i], i); end
    end
    checks++; if (!(acc4_cyc > first_pop && first_pop >= 0)) begin
      failures++; $display("FAIL bp_resume got=accept@%0d pop@%0d exp=accept after pop", acc4_cyc, first_pop); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic [3:0] tg; logic er; int lat;
    xact(1'b1, 32'h22, 32'h5, 4'd7, rd, tg, er, lat);
    checks++; if ({rd, tg, er} !== {32'h0, 4'd7, 1'b1} || lat != LAT) begin
      failures++; $display("FAIL mis_store got=%h t%0d e%b lat%0d exp=0 t7 e1 lat%0d", rd, tg, er, lat, LAT); end
    xact(1'b0, 32'h20, 32'h0, 4'd8, rd, tg, er, lat);
    checks++; if ({rd, tg, er} !== {32'h0, 4'd8, 1'b0} || lat != LAT) begin
      failures++; $display("FAIL mis_load got=%h t%0d e%b lat%0d exp=0 t8 e0 lat%0d", rd, tg, er, lat, LAT); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic [3:0] tg; logic er; int lat;
    xact(1'b1, 32'h404, 32'hA5, 4'd9, rd, tg, er, lat);
    checks++; if ({rd, tg, er} !== {32'hA5, 4'd9, 1'b0}) begin
      failures++; $display("FAIL wrap_store got=%h t%0d e%b exp=a5 t9 e0", rd, tg, er); end
    xact(1'b0, 32'h004, 32'h0, 4'd10, rd, tg, er, lat);
    checks++; if ({rd, tg, er} !== {32'hA5, 4'd10, 1'b0} || lat != LAT) begin
      failures++; $display("FAIL wrap_load got=%h t%0d e%b lat%0d exp=a5 t10 e0 lat%0d", rd, tg, er, lat, LAT); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] rd; logic [3:0] tg; logic er; int lat;
    int got_n = 0;
    xact(1'b1, 32'h30, 32'h1234, 4'd1, rd, tg, er, lat);
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h30;
    for (int i = 0; i < 3; i++) begin req_tag_i = 4'(i); tick; end
    req_valid_i = 1'b0;
    checks++; if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", resp_valid_o); end
    #2 reset_i = 1'b1;
    #1;
    checks++; if ({req_ready_o, resp_valid_o, resp_rdata_o, resp_tag_o, resp_err_o} !== 39'd0) begin
      failures++; $display("FAIL mid_async got=r%b v%b %h t%0d e%b exp=all 0", req_ready_o, resp_valid_o, resp_rdata_o, resp_tag_o, resp_err_o); end
    tick; tick;
    reset_i = 1'b0;
    tick;
    resp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", i, resp_valid_o); end
      tick;
    end
    resp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 32'h30;
    for (int i = 0; i < DEPTH; i++) begin
      req_tag_i = 4'(i + 4);
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL mid_credit cyc=%0d got=%b exp=1", i, req_ready_o); end
      tick;
    end
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    for (int c = 0; c < 20 && got_n < DEPTH; c++) begin
      if (resp_valid_o === 1'b1) begin
        checks++; if (resp_rdata_o !== 32'h0 || resp_tag_o !== 4'(got_n + 4)) begin
          failures++; $display("FAIL mid_mem idx=%0d got=%h t%0d exp=0 t%0d", got_n, resp_rdata_o, resp_tag_o, got_n + 4); end
        got_n++;
      end
      tick;
    end
    checks++; if (got_n != DEPTH) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", got_n, DEPTH); end
  endtask

  typedef struct { logic [31:0] data; logic [3:0] tag; logic err; int avail; } exp_t;

  task automatic test_random;
    logic [31:0] mm [256];
    exp_t q [$];
    exp_t e;
    int out_n = 0;
    bit exp_ready = 1'b1, exp_valid, acc, pop, hold = 1'b0;
    for (int i = 0; i < 256; i++) mm[i] = '0;
    req_valid_i = 1'b0; resp_ready_i = 1'b0;
    reset_i = 1'b1; tick; tick; reset_i = 1'b0; tick;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
      checks++; if (req_ready_o !== exp_ready) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_ready); end
      checks++; if (resp_valid_o !== exp_valid) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, resp_valid_o, exp_valid); end
      else if (exp_valid) begin
        checks++; if ({resp_rdata_o, resp_tag_o, resp_err_o} !== {q[0].data, q[0].tag, q[0].err}) begin
          failures++; $display("FAIL rnd_resp cyc=%0d got=%h t%0d e%b exp=%h t%0d e%b", cyc,
            resp_rdata_o, resp_tag_o, resp_err_o, q[0].data, q[0].tag, q[0].err); end
      end
      if (!hold) begin
        req_valid_i = ($urandom_range(0, 2) != 0);
        req_we_i    = $urandom_range(0, 1) == 1;
        req_addr_i  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2)
                      | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        req_wdata_i = $urandom;
        req_tag_i   = 4'($urandom);
      end
      resp_ready_i = ($urandom_range(0, 3) != 0);
      acc  = req_valid_i && exp_ready;
      pop  = exp_valid && resp_ready_i;
      hold = req_valid_i && !acc;
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.tag = req_tag_i; e.avail = cyc + 1 + LAT;
        e.err = (req_addr_i % 4) != 0;
        if (e.err) e.data = '0;
        else if (req_we_i) begin e.data = req_wdata_i; mm[(req_addr_i / 4) % 256] = req_wdata_i; end
        else e.data = mm[(req_addr_i / 4) % 256];
        q.push_back(e);
      end
      out_n = out_n + int'(acc) - int'(pop);
      exp_ready = (out_n < DEPTH);
      tick;
    end
    req_valid_i = 1'b0;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_backpressure;
    test_misaligned;
    test_wrap;
    test_reset_midop;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
